// File: rtl/store_pkg.sv
// Shared definitions for the store-path write buffer.
//   OP_*          : MIPS store opcodes (IR[31:26])
//   store_entry_t : queued store layout for the default 32-bit configuration.
//                   The buffer declares a width-parameterised twin of it.
package store_pkg;

  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SWL = 6'b101010;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SWR = 6'b101110;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } store_entry_t;

endpackage

// File: rtl/store_lane_align.sv
// Combinational lane aligner for MIPS stores (big-endian byte lanes).
//   op         : IR[31:26]
//   offset     : low log2(DATA_W/8) bits of the byte address
//   rt         : Rt register value
//   data       : lane-aligned write data
//   be         : byte enables, be[j] covers data[8j+7:8j]
//   is_store   : op is one of SB/SH/SW/SWL/SWR
//   misaligned : SH on an odd address or SW off a word boundary
module store_lane_align
  import store_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [5:0]                   op,
  input  logic [$clog2(DATA_W/8)-1:0]  offset,
  input  logic [31:0]                  rt,
  output logic [DATA_W-1:0]            data,
  output logic [DATA_W/8-1:0]          be,
  output logic                         is_store,
  output logic                         misaligned
);

  localparam int WORDS = DATA_W / 32;

  logic [1:0]  w;
  logic        slot;
  logic [31:0] wdata;
  logic [3:0]  wmask;     // bit 3 = byte 0 of the word (big-endian)
  logic        replicate;
  logic [WORDS-1:0][31:0] lane_data;
  logic [WORDS-1:0][3:0]  lane_be;

  assign w = offset[1:0];

  // Word slot inside a 64-bit beat; word 0 lives in the upper half.
  generate
    if (DATA_W == 64) begin : g_slot
      assign slot = offset[$clog2(DATA_W/8)-1];
    end else begin : g_noslot
      assign slot = 1'b0;
    end
  endgenerate

  always_comb begin
    wdata      = '0;
    wmask      = '0;
    replicate  = 1'b1;
    is_store   = 1'b1;
    misaligned = 1'b0;
    case (op)
      OP_SB:  begin wdata = {4{rt[7:0]}};  wmask = 4'b1000 >> w; end
      OP_SH:  begin
        wdata = {2{rt[15:0]}}; wmask = 4'b1100 >> {w[1], 1'b0};
        misaligned = w[0];
      end
      OP_SW:  begin wdata = rt; wmask = 4'hF; misaligned = (w != 2'd0); end
      // Partial words: unused lanes carry zero rather than replicas.
      OP_SWL: begin wdata = rt >> {w, 3'b000};  wmask = 4'hF >> w;  replicate = 1'b0; end
      OP_SWR: begin wdata = rt << {~w, 3'b000}; wmask = 4'hF << ~w; replicate = 1'b0; end
      default: is_store = 1'b0;
    endcase
  end

  always_comb begin
    lane_data = '0;
    lane_be   = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (i == WORDS - 1 - int'(slot)) begin
        lane_data[i] = wdata;
        lane_be[i]   = wmask;
      end else if (replicate) begin
        lane_data[i] = wdata;
      end
    end
  end

  assign data = lane_data;
  assign be   = lane_be;

endmodule

// File: rtl/store_align_buffer.sv
// Store-path write buffer: aligns MIPS stores and queues them for memory.
//   clk, rst          : clock, synchronous active-high reset
//   flush             : drop every queued store
//   in_valid/in_ready : store request handshake (in_ready = !full)
//   in_op/addr/data   : IR[31:26], byte address, Rt value
//   out_valid/ready   : head-of-queue handshake toward memory
//   out_addr/data/be  : beat-aligned address, lane data, byte enables
//   misalign_err      : one-cycle pulse after a rejected store
//   err_addr          : address of the last rejected store
//   count             : entries held
module store_align_buffer
  import store_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [5:0]                in_op,
  input  logic [ADDR_W-1:0]         in_addr,
  input  logic [31:0]               in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ADDR_W-1:0]         out_addr,
  output logic [DATA_W-1:0]         out_data,
  output logic [DATA_W/8-1:0]       out_be,
  output logic                      misalign_err,
  output logic [ADDR_W-1:0]         err_addr,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [BYTES-1:0]  be;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             head;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [DATA_W-1:0]  al_data;
  logic [BYTES-1:0]   al_be;
  logic               al_store, al_mis;
  logic               accept, push, pop, bad_store;

  store_lane_align #(.DATA_W(DATA_W)) u_align (
    .op         (in_op),
    .offset     (in_addr[OFF_W-1:0]),
    .rt         (in_data),
    .data       (al_data),
    .be         (al_be),
    .is_store   (al_store),
    .misaligned (al_mis)
  );

  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign accept    = in_valid & in_ready;
  assign bad_store = accept & al_store & al_mis;
  // Flush wins over a same-cycle push.
  assign push      = accept & al_store & ~al_mis & ~flush;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      misalign_err <= 1'b0;
      err_addr     <= '0;
    end else begin
      misalign_err <= bad_store;
      if (bad_store) err_addr <= in_addr;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // Storage needs no reset: outputs are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= '{addr: {in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}},
                       data: al_data, be: al_be};
  end

  assign head     = mem[rd_ptr];
  assign out_addr = out_valid ? head.addr : '0;
  assign out_data = out_valid ? head.data : '0;
  assign out_be   = out_valid ? head.be   : '0;

endmodule

// File: tb/tb_store_align_buffer.sv
module tb_store_align_buffer;
  import store_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [5:0]  in_op = '0;
  logic [31:0] in_addr = '0, in_data = '0;
  logic        in_ready, out_valid, misalign_err;
  logic [31:0] out_addr, out_data, err_addr;
  logic [3:0]  out_be;
  logic [2:0]  count;

  // 64-bit instance
  logic        w_in_valid = 1'b0, w_out_ready = 1'b0;
  logic [5:0]  w_in_op = '0;
  logic [31:0] w_in_addr = '0, w_in_data = '0;
  logic        w_in_ready, w_out_valid, w_misalign_err;
  logic [31:0] w_out_addr, w_err_addr;
  logic [63:0] w_out_data;
  logic [7:0]  w_out_be;
  logic [2:0]  w_count;

  store_align_buffer #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_addr(in_addr), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data), .out_be(out_be),
    .misalign_err(misalign_err), .err_addr(err_addr), .count(count));

  store_align_buffer #(.DATA_W(64), .ADDR_W(32), .DEPTH(DEPTH)) dut64 (
    .clk(clk), .rst(rst), .flush(1'b0), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_op(w_in_op), .in_addr(w_in_addr), .in_data(w_in_data), .out_valid(w_out_valid),
    .out_ready(w_out_ready), .out_addr(w_out_addr), .out_data(w_out_data), .out_be(w_out_be),
    .misalign_err(w_misalign_err), .err_addr(w_err_addr), .count(w_count));

  int total = 0, bad = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } exp_t;

  exp_t sb_q[$];
  exp_t exp_e;
  logic exp_legal = 1'b0;

  // Byte-by-byte reference: word byte j (big-endian) lands in data[8*(3-j)+:8].
  task automatic model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] rt,
                       output exp_t e, output logic legal);
    logic [7:0] b[4];
    int w;
    logic st;
    b[0] = rt[31:24]; b[1] = rt[23:16]; b[2] = rt[15:8]; b[3] = rt[7:0];
    w = int'(a[1:0]);
    e.addr = {a[31:2], 2'b00}; e.data = '0; e.be = '0; st = 1'b1;
    for (int j = 0; j < 4; j++) begin
      logic [7:0] v;
      logic en;
      v = '0; en = 1'b0;
      case (op)
        OP_SB:  begin v = b[3]; en = (j == w); end
        OP_SH:  begin v = (j % 2 == 0) ? b[2] : b[3]; en = (j / 2 == w / 2); end
        OP_SW:  begin v = b[j]; en = 1'b1; end
        OP_SWL: if (j >= w) begin v = b[j - w]; en = 1'b1; end
        OP_SWR: if (j <= w) begin v = b[3 - w + j]; en = 1'b1; end
        default: st = 1'b0;
      endcase
      e.data[8*(3-j) +: 8] = v;
      e.be[3-j] = en;
    end
    legal = st && !(op == OP_SH && a[0]) && !(op == OP_SW && w != 0);
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] rt);
    in_valid = 1'b1; in_op = op; in_addr = a; in_data = rt;
    model(op, a, rt, exp_e, exp_legal);
  endtask

  // One clock: scoreboard pop/compare and push, sampled 1 time unit into the low phase.
  task automatic tick();
    bit full_m;
    #1;
    full_m = (sb_q.size() >= DEPTH);
    if (out_ready && sb_q.size() != 0 && !out_valid) begin
      total++; bad++;
      $display("FAIL sb_stall out_valid=0 want=1 (queued=%0d)", sb_q.size());
    end
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_unexpected_pop addr=%h want=no entry", out_addr);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        total++;
        if (out_addr !== e.addr || out_data !== e.data || out_be !== e.be) begin
          bad++;
          $display("FAIL sb_entry got=%h/%h/%b want=%h/%h/%b",
                   out_addr, out_data, out_be, e.addr, e.data, e.be);
        end
      end
    end
    if (rst || flush) sb_q.delete();
    else if (in_valid && !full_m && exp_legal) sb_q.push_back(exp_e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    total++; if (in_ready !== 1'b1)      begin bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0)     begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
    total++; if (count !== 3'd0)         begin bad++; $display("FAIL rst_count got=%0d want=0", count); end
    total++; if (misalign_err !== 1'b0)  begin bad++; $display("FAIL rst_err got=%b want=0", misalign_err); end
    total++; if (err_addr !== 32'h0)     begin bad++; $display("FAIL rst_err_addr got=%h want=0", err_addr); end
    total++; if (out_addr !== 32'h0 || out_data !== 32'h0 || out_be !== 4'h0) begin
      bad++; $display("FAIL rst_out got=%h/%h/%b want=0/0/0", out_addr, out_data, out_be); end
    rst = 1'b0;
  endtask

  task automatic test_align();
    out_ready = 1'b0;
    drive(OP_SB, 32'h1001, 32'h11223344);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sb_bypass out_valid got=%b want=0", out_valid); end
    tick(); in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL sb_latency out_valid got=%b want=1", out_valid); end
    total++; if (out_addr !== 32'h1000 || out_data !== 32'h44444444 || out_be !== 4'b0100) begin
      bad++; $display("FAIL sb_fields got=%h/%h/%b want=00001000/44444444/0100", out_addr, out_data, out_be); end
    tick();
    total++; if (out_data !== 32'h44444444) begin bad++; $display("FAIL sb_stable got=%h want=44444444", out_data); end
    out_ready = 1'b1;
    tick();
    drive(OP_SWL, 32'h2002, 32'h11223344); tick();
    total++; if (out_data !== 32'h00001122 || out_be !== 4'b0011) begin
      bad++; $display("FAIL swl got=%h/%b want=00001122/0011", out_data, out_be); end
    drive(OP_SWR, 32'h2001, 32'h11223344); tick();
    total++; if (out_data !== 32'h33440000 || out_be !== 4'b1100) begin
      bad++; $display("FAIL swr got=%h/%b want=33440000/1100", out_data, out_be); end
    drive(OP_SW, 32'h2000, 32'h11223344); tick();
    total++; if (out_data !== 32'h11223344 || out_be !== 4'b1111) begin
      bad++; $display("FAIL sw got=%h/%b want=11223344/1111", out_data, out_be); end
    drive(OP_SH, 32'h2002, 32'h11223344); tick();
    in_valid = 1'b0;
    tick(); tick();
    total++; if (count !== 3'd0) begin bad++; $display("FAIL align_drain count got=%0d want=0", count); end
  endtask

  task automatic test_misalign();
    out_ready = 1'b0;
    drive(OP_SW, 32'h1002, 32'h11223344); tick(); in_valid = 1'b0;
    total++; if (misalign_err !== 1'b1 || err_addr !== 32'h1002) begin
      bad++; $display("FAIL mis_sw got=%b/%h want=1/00001002", misalign_err, err_addr); end
    tick();
    total++; if (misalign_err !== 1'b0 || err_addr !== 32'h1002) begin
      bad++; $display("FAIL mis_pulse got=%b/%h want=0/00001002", misalign_err, err_addr); end
    drive(OP_SH, 32'h1003, 32'h11223344); tick(); in_valid = 1'b0;
    total++; if (misalign_err !== 1'b1 || err_addr !== 32'h1003) begin
      bad++; $display("FAIL mis_sh got=%b/%h want=1/00001003", misalign_err, err_addr); end
    drive(6'b100011, 32'h1005, 32'h11223344); tick(); in_valid = 1'b0;
    total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL nonstore_err got=%b want=0", misalign_err); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL mis_count got=%0d want=0", count); end
  endtask

  task automatic test_full();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(OP_SW, 32'h4000 + 32'(4 * i), 32'hA0000000 + 32'(i));
      total++; if (in_ready !== (i < 4)) begin bad++; $display("FAIL full_in_ready i=%0d got=%b want=%b", i, in_ready, i < 4); end
      tick();
    end
    in_valid = 1'b0;
    total++; if (count !== 3'd4) begin bad++; $display("FAIL full_count got=%0d want=4", count); end
    drive(OP_SW, 32'h4100, 32'hBEEF0000); out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_pop_ready got=%b want=0", in_ready); end
    tick();
    total++; if (count !== 3'd3) begin bad++; $display("FAIL full_pop_count got=%0d want=3", count); end
    for (int i = 0; i < 3; i++) begin
      drive(OP_SW, 32'h4200 + 32'(4 * i), 32'hC0000000 + 32'(i));
      tick();
      total++; if (count !== 3'd3) begin bad++; $display("FAIL pushpop_count i=%0d got=%0d want=3", i, count); end
    end
    in_valid = 1'b0;
    tick(); tick(); tick();
    total++; if (count !== 3'd0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL full_drain got=%0d/%b want=0/0", count, out_valid); end
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin drive(OP_SW, 32'h5000 + 32'(4 * i), 32'h55550000 + 32'(i)); tick(); end
    in_valid = 1'b0;
    total++; if (count !== 3'd3) begin bad++; $display("FAIL flush_pre got=%0d want=3", count); end
    drive(OP_SW, 32'h5100, 32'h12345678); flush = 1'b1; tick(); flush = 1'b0; in_valid = 1'b0;
    total++; if (count !== 3'd0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL flush got=%0d/%b want=0/0", count, out_valid); end
    drive(OP_SW, 32'h5002, 32'h12345678); flush = 1'b1; tick(); flush = 1'b0; in_valid = 1'b0;
    total++; if (misalign_err !== 1'b1 || err_addr !== 32'h5002) begin
      bad++; $display("FAIL flush_err got=%b/%h want=1/00005002", misalign_err, err_addr); end
  endtask

  task automatic test_rst_mid_drain();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin drive(OP_SB, 32'h7000 + 32'(i), 32'h000000A0 + 32'(i)); tick(); end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    total++; if (count !== 3'd2) begin bad++; $display("FAIL drain_one got=%0d want=2", count); end
    rst = 1'b1; tick(); rst = 1'b0; out_ready = 1'b0;
    total++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL rst_mid got=%0d/%b/%b want=0/0/1", count, out_valid, in_ready); end
    total++; if (out_data !== 32'h0 || err_addr !== 32'h0) begin
      bad++; $display("FAIL rst_mid_regs got=%h/%h want=0/0", out_data, err_addr); end
  endtask

  task automatic test_random();
    logic [5:0] ops[6];
    ops[0] = OP_SB; ops[1] = OP_SH; ops[2] = OP_SW; ops[3] = OP_SWL; ops[4] = OP_SWR; ops[5] = 6'b100011;
    for (int i = 0; i < 80; i++) begin
      drive(ops[$urandom_range(0, 5)], 32'h6000 + 32'($urandom_range(0, 63)), $urandom);
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) tick();
    total++; if (sb_q.size() != 0 || count !== 3'd0) begin
      bad++; $display("FAIL rand_drain count=%0d want=0 (model left %0d)", count, sb_q.size()); end
    out_ready = 1'b0;
  endtask

  task automatic test_wide64();
    w_out_ready = 1'b0;
    w_in_valid = 1'b1; w_in_op = OP_SW; w_in_addr = 32'h3004; w_in_data = 32'hAABBCCDD;
    tick(); w_in_valid = 1'b0;
    total++; if (w_out_valid !== 1'b1 || w_out_addr !== 32'h3000) begin
      bad++; $display("FAIL w64_sw_addr got=%b/%h want=1/00003000", w_out_valid, w_out_addr); end
    total++; if (w_out_data !== 64'hAABBCCDDAABBCCDD || w_out_be !== 8'h0F) begin
      bad++; $display("FAIL w64_sw got=%h/%h want=aabbccddaabbccdd/0f", w_out_data, w_out_be); end
    w_out_ready = 1'b1; tick();
    w_in_valid = 1'b1; w_in_op = OP_SB; w_in_addr = 32'h3005; w_in_data = 32'h000000DD;
    tick(); w_in_valid = 1'b0;
    total++; if (w_out_data !== 64'hDDDDDDDDDDDDDDDD || w_out_be !== 8'h04) begin
      bad++; $display("FAIL w64_sb got=%h/%h want=dddddddddddddddd/04", w_out_data, w_out_be); end
    w_in_valid = 1'b1; w_in_op = OP_SWL; w_in_addr = 32'h3001; w_in_data = 32'h11223344;
    tick(); w_in_valid = 1'b0;
    total++; if (w_out_data !== 64'h0011223300000000 || w_out_be !== 8'h70) begin
      bad++; $display("FAIL w64_swl got=%h/%h want=0011223300000000/70", w_out_data, w_out_be); end
    tick();
    total++; if (w_count !== 3'd0) begin bad++; $display("FAIL w64_drain got=%0d want=0", w_count); end
  endtask

  initial begin
    test_reset();
    test_align();
    test_misalign();
    test_full();
    test_flush();
    test_rst_mid_drain();
    test_random();
    test_wide64();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
